// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter: FSM states, transaction owner
// and the latched bus command.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    localparam int DEF_MAX_DSTREAK    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory port bundle: the arbiter is the master, the memory is the slave.
interface mem_port_arbiter_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant picker: data wins unless fetch has been starved for a full streak.
module mem_arb_pick (
    input  logic d_req_i,
    input  logic if_req_i,
    input  logic flush_i,
    input  logic dstreak_sat_i,
    output logic gnt_d_o,
    output logic gnt_if_o
);

    logic fetch_live;

    // A flushed fetch is not a competitor: it can neither win nor block data.
    assign fetch_live = if_req_i && !flush_i;
    assign gnt_d_o    = d_req_i && !(fetch_live && dstreak_sat_i);
    assign gnt_if_o   = !gnt_d_o && fetch_live;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data requesters,
// one outstanding transaction at a time (IDLE -> REQ -> RSP).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK    = DEF_MAX_DSTREAK,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_i,
    input  logic [31:0]         if_addr_i,
    input  logic                flush_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [31:0]         if_rdata_o,
    output logic                if_err_o,

    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [3:0]          d_be_i,
    input  logic [31:0]         d_addr_i,
    input  logic [31:0]         d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [31:0]         d_rdata_o,
    output logic                d_err_o,

    mem_port_arbiter_if.master  mem
);

    localparam int SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TLAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic        drop_q, drop_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic pick_d, pick_if, dstreak_sat, timeout_hit, in_idle, in_rsp;
    logic [31:0] rsp_word;

    assign dstreak_sat = (dstreak_q == SW'(MAX_DSTREAK));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TW'(TLAST));
    assign in_idle     = (state_q == IDLE);
    assign in_rsp      = (state_q == RSP);

    mem_arb_pick u_pick (
        .d_req_i       (d_req_i),
        .if_req_i      (if_req_i),
        .flush_i       (flush_i),
        .dstreak_sat_i (dstreak_sat),
        .gnt_d_o       (pick_d),
        .gnt_if_o      (pick_if)
    );

    // Grants are combinational, so they are also gated by reset to keep outputs quiet.
    assign d_gnt_o  = in_idle && !rst && pick_d;
    assign if_gnt_o = in_idle && !rst && pick_if;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        dstreak_d  = dstreak_q;
        tcnt_d     = tcnt_q;
        drop_d     = drop_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        rsp_word   = '0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (pick_d) begin
                    owner_d = OWN_D;
                    cmd_d   = '{we: d_we_i, be: d_be_i, addr: d_addr_i, wdata: d_wdata_i};
                    state_d = REQ;
                    tcnt_d  = '0;
                    if (if_req_i && !flush_i)
                        dstreak_d = dstreak_sat ? dstreak_q : dstreak_q + SW'(1);
                    else
                        dstreak_d = '0;
                end else if (pick_if) begin
                    owner_d   = OWN_IF;
                    cmd_d     = '{we: 1'b0, be: 4'hF, addr: if_addr_i, wdata: 32'h0};
                    state_d   = REQ;
                    tcnt_d    = '0;
                    dstreak_d = '0;
                end
            end

            REQ: begin
                if (flush_i && owner_q == OWN_IF)
                    drop_d = 1'b1;
                // Ack wins over a timeout landing in the same cycle.
                if (mem.ack || timeout_hit) begin
                    rsp_word = (mem.ack && !cmd_q.we) ? mem.rdata : 32'h0;
                    err_d    = !mem.ack;
                    state_d  = RSP;
                    if (owner_q == OWN_D)
                        d_rdata_d = rsp_word;
                    else
                        if_rdata_d = rsp_word;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            RSP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            cmd_q      <= '0;
            dstreak_q  <= '0;
            tcnt_q     <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            dstreak_q  <= dstreak_d;
            tcnt_q     <= tcnt_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem.req   = (state_q == REQ);
    assign mem.we    = cmd_q.we;
    assign mem.be    = cmd_q.be;
    assign mem.addr  = cmd_q.addr;
    assign mem.wdata = cmd_q.wdata;

    // A flush arriving in the response cycle itself still hides the fetch response.
    assign if_rvalid_o = in_rsp && owner_q == OWN_IF && !drop_q && !flush_i;
    assign if_err_o    = if_rvalid_o && err_q;
    assign if_rdata_o  = if_rdata_q;

    assign d_rvalid_o  = in_rsp && owner_q == OWN_D;
    assign d_err_o     = d_rvalid_o && err_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

    localparam int MAXD = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, flush, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;

    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .flush_i     (flush),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .if_err_o    (if_err),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_be_i      (d_be),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .mem         (mem_bus)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_d;
    } txn_t;

    // Reference model: one transaction in flight, described by its age on the bus
    // and whether a reply is due this cycle.
    txn_t        cur;
    bit          m_busy, m_reply, dropped, rsp_err, last_gnt_if, last_gnt_d;
    int          m_age, streak, ack_delay;
    logic [31:0] rsp_data;
    bit          gnt_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur = '0; m_busy = 0; m_reply = 0; dropped = 0; rsp_err = 0;
        m_age = 0; streak = 0; rsp_data = '0; last_gnt_if = 0; last_gnt_d = 0;
    endtask

    // Called at posedge+1 with inputs driven; checks at mid-cycle, advances the model.
    task automatic step();
        bit want_if, pick_d, pick_if, e_if_rv, e_d_rv;
        #4;
        want_if = if_req && !flush;
        pick_d  = !m_busy && !m_reply && d_req && !(want_if && streak >= MAXD);
        pick_if = !m_busy && !m_reply && !pick_d && want_if;
        check("if_gnt", if_gnt, pick_if);
        check("d_gnt", d_gnt, pick_d);
        check("mem_req", mem_bus.req, m_busy);
        if (m_busy) begin
            check("mem_we", mem_bus.we, cur.we);
            check("mem_be", mem_bus.be, cur.be);
            check("mem_addr", mem_bus.addr, cur.addr);
            check("mem_wdata", mem_bus.wdata, cur.wdata);
        end
        e_if_rv = m_reply && !cur.is_d && !dropped && !flush;
        e_d_rv  = m_reply && cur.is_d;
        check("if_rvalid", if_rvalid, e_if_rv);
        check("d_rvalid", d_rvalid, e_d_rv);
        if (e_if_rv) begin
            check("if_rdata", if_rdata, rsp_data);
            check("if_err", if_err, rsp_err);
        end
        if (e_d_rv) begin
            check("d_rdata", d_rdata, rsp_data);
            check("d_err", d_err, rsp_err);
        end
        if (if_gnt === 1'b1) gnt_log.push_back(1'b0);
        else if (d_gnt === 1'b1) gnt_log.push_back(1'b1);

        last_gnt_if = pick_if;
        last_gnt_d  = pick_d;
        if (m_reply) begin
            m_reply = 0;
        end else if (m_busy) begin
            if (flush && !cur.is_d) dropped = 1;
            m_age++;
            if (mem_bus.ack) begin
                rsp_data = cur.we ? 32'h0 : mem_bus.rdata;
                rsp_err  = 0;
                m_busy   = 0;
                m_reply  = 1;
            end else if (m_age == TMO) begin
                rsp_data = 32'h0;
                rsp_err  = 1;
                m_busy   = 0;
                m_reply  = 1;
            end
        end else if (pick_d || pick_if) begin
            if (pick_d) begin
                cur    = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata, is_d: 1'b1};
                streak = want_if ? ((streak + 1 > MAXD) ? MAXD : streak + 1) : 0;
            end else begin
                cur    = '{we: 1'b0, be: 4'hF, addr: if_addr, wdata: 32'h0, is_d: 1'b0};
                streak = 0;
            end
            m_busy    = 1;
            m_age     = 0;
            dropped   = 0;
            ack_delay = ($urandom_range(0, 5) == 5) ? 99 : int'($urandom_range(0, 4));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
        check({tag, "_mem_req"}, mem_bus.req, 1'b0);
        check({tag, "_mem_addr"}, mem_bus.addr, 32'd0);
        check({tag, "_mem_be"}, {mem_bus.we, mem_bus.be}, 5'd0);
        check({tag, "_rvalid"}, {28'd0, if_rvalid, if_err, d_rvalid, d_err}, 32'd0);
        check({tag, "_rdata"}, if_rdata | d_rdata, 32'd0);
    endtask

    task automatic lone_fetch(input logic [31:0] addr, input logic [31:0] word);
        if_req = 1; if_addr = addr; d_req = 0; flush = 0; mem_bus.ack = 0;
        step();
        if_req = 0; mem_bus.ack = 1; mem_bus.rdata = word;
        step();
        mem_bus.ack = 0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_order[10];
        rst = 1;
        if_req = 1; if_addr = 32'h40; flush = 0;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h80; d_wdata = 0;
        mem_bus.ack = 0; mem_bus.rdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #5;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 0;
        if_req = 0; d_req = 0;

        // Lone fetch with ack in the first REQ cycle.
        lone_fetch(32'h100, 32'hDEADBEEF);

        // Both requesters continuously busy, instant ack: D,D,D,D,IF pattern.
        gnt_log.delete();
        for (int i = 0; i < 30; i++) begin
            if_req = 1; if_addr = $urandom;
            d_req = 1; d_we = $urandom; d_be = $urandom; d_addr = $urandom; d_wdata = $urandom;
            mem_bus.ack = 1; mem_bus.rdata = $urandom;
            step();
        end
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        check("order_len", gnt_log.size(), 10);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++)
            check($sformatf("order_%0d", i), gnt_log[i], exp_order[i]);
        if_req = 0; d_req = 0; mem_bus.ack = 0;
        step();

        // Store, ack in the third REQ cycle.
        d_req = 1; d_we = 1; d_be = 4'b1100; d_addr = 32'h22; d_wdata = 32'h12345678;
        step();
        d_req = 0;
        step(); step();
        mem_bus.ack = 1; mem_bus.rdata = 32'hCAFEF00D;
        step();
        mem_bus.ack = 0;
        step();

        // Fetch flushed while on the bus; transaction completes but is not reported.
        if_req = 1; if_addr = 32'h200;
        step();
        if_req = 0; flush = 1;
        step();
        flush = 0;
        step();
        mem_bus.ack = 1; mem_bus.rdata = 32'h55AA55AA;
        step();
        mem_bus.ack = 0;
        step();
        lone_fetch(32'h300, 32'h0BADC0DE);

        // Load with no ack: error after TMO REQ cycles.
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h44;
        step();
        d_req = 0;
        repeat (TMO) step();
        step();

        // Reset in the middle of a REQ phase.
        if_req = 1; if_addr = 32'h400;
        step();
        if_req = 0;
        #2;
        rst = 1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        lone_fetch(32'h100, 32'hDEADBEEF);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (!if_req || last_gnt_if) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!d_req || last_gnt_d) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom;
                d_be    = $urandom;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            flush         = ($urandom_range(0, 7) == 0);
            mem_bus.ack   = m_busy && (m_age == ack_delay);
            mem_bus.rdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
